// File: rtl/lcd_text_sequencer_if.sv
// Byte-transaction handshake between the text sequencer and the
// character-LCD write controller.
interface lcd_text_sequencer_if;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_START;
    logic       iLCD_DONE;

    modport master (
        output oLCD_DATA,
        output oLCD_RS,
        output oLCD_START,
        input  iLCD_DONE
    );

    modport slave (
        input  oLCD_DATA,
        input  oLCD_RS,
        input  oLCD_START,
        output iLCD_DONE
    );
endinterface

// File: rtl/lcd_text_sequencer.sv
// HD44780 init + 2x16 frame streamer feeding the LCD write controller.
// Host writes the frame buffer; a refresh re-streams it without init.
module lcd_text_sequencer #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int CMD_DELAY      = 2000,
    parameter int CLR_DELAY      = 82000
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iWR,
    input  logic [4:0]            iADDR,
    input  logic [7:0]            iCHAR,
    input  logic                  iREFRESH,
    output logic                  oBusy,
    lcd_text_sequencer_if.master  lcd
);

    localparam int MAXA = (POWERUP_CYCLES > CMD_DELAY) ? POWERUP_CYCLES : CMD_DELAY;
    localparam int MAXC = (MAXA > CLR_DELAY) ? MAXA : CLR_DELAY;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_DELAY - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_DELAY - 1);

    localparam logic [5:0] ITEM_CLR  = 6'd2;
    localparam logic [5:0] ITEM_HOME = 6'd4;
    localparam logic [5:0] ITEM_LAST = 6'd37;

    typedef enum logic [2:0] {
        PWRUP,
        SETUP,
        START,
        WAIT,
        GAP,
        IDLE
    } state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [5:0]    item, itemNext;
    logic [1:0]    blank, blankNext;
    logic          pending, pendingNext;
    logic [7:0]    lcdData, lcdDataNext;
    logic          lcdRs, lcdRsNext;
    logic          lcdStart, lcdStartNext;

    logic [7:0]    frame [32];
    logic [7:0]    itemData;
    logic          itemRs;
    logic          gapLast;

    // Host writes land in the frame buffer in every state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) begin
                frame[i] <= 8'h20;
            end
        end else if (iWR) begin
            frame[iADDR] <= iCHAR;
        end
    end

    // Byte and RS for the current item of the stream.
    always_comb begin
        itemData = 8'h00;
        itemRs   = 1'b0;
        unique case (1'b1)
            (item < 6'd5): begin
                unique case (item[2:0])
                    3'd0:    itemData = 8'h38;
                    3'd1:    itemData = 8'h0C;
                    3'd2:    itemData = 8'h01;
                    3'd3:    itemData = 8'h06;
                    default: itemData = 8'h80;
                endcase
            end
            (item >= 6'd5 && item <= 6'd20): begin
                itemData = frame[5'(item - 6'd5)];
                itemRs   = 1'b1;
            end
            (item == 6'd21): begin
                itemData = 8'hC0;
            end
            default: begin
                itemData = frame[5'(item - 6'd6)];
                itemRs   = 1'b1;
            end
        endcase
    end

    // Clear-display needs the long settle time; everything else the short one.
    always_comb begin
        gapLast = (item == ITEM_CLR) ? (cnt == CLR_LAST) : (cnt == CMD_LAST);
    end

    // State, counters and the registered controller-facing outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= PWRUP;
            cnt      <= '0;
            item     <= '0;
            blank    <= '0;
            pending  <= 1'b0;
            lcdData  <= 8'h00;
            lcdRs    <= 1'b0;
            lcdStart <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            item     <= itemNext;
            blank    <= blankNext;
            pending  <= pendingNext;
            lcdData  <= lcdDataNext;
            lcdRs    <= lcdRsNext;
            lcdStart <= lcdStartNext;
        end
    end

    // Next-state: power-up wait, per-item handshake, inter-item gap, idle.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        itemNext     = item;
        blankNext    = blank;
        pendingNext  = pending;
        lcdDataNext  = lcdData;
        lcdRsNext    = lcdRs;
        lcdStartNext = lcdStart;

        if (iREFRESH && state != IDLE) begin
            pendingNext = 1'b1;
        end

        unique case (state)
            PWRUP: begin
                if (cnt == PWR_LAST) begin
                    cntNext   = '0;
                    itemNext  = '0;
                    stateNext = SETUP;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            SETUP: begin
                lcdDataNext = itemData;
                lcdRsNext   = itemRs;
                stateNext   = START;
            end
            START: begin
                lcdStartNext = 1'b1;
                blankNext    = 2'd2;
                stateNext    = WAIT;
            end
            WAIT: begin
                // Done is masked while the controller may still show
                // the previous transaction's completion.
                if (blank != 2'd0) begin
                    blankNext = blank - 1'b1;
                end else if (lcd.iLCD_DONE) begin
                    lcdStartNext = 1'b0;
                    cntNext      = '0;
                    stateNext    = GAP;
                end
            end
            GAP: begin
                if (gapLast) begin
                    cntNext = '0;
                    if (item == ITEM_LAST) begin
                        stateNext = IDLE;
                    end else begin
                        itemNext  = item + 1'b1;
                        stateNext = SETUP;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (iREFRESH || pending) begin
                    pendingNext = 1'b0;
                    itemNext    = ITEM_HOME;
                    stateNext   = SETUP;
                end
            end
            default: begin
                stateNext = PWRUP;
            end
        endcase
    end

    assign oBusy          = (state != IDLE);
    assign lcd.oLCD_DATA  = lcdData;
    assign lcd.oLCD_RS    = lcdRs;
    assign lcd.oLCD_START = lcdStart;

endmodule
